booth_accumulator: RTL and testbench

Sequential consumer of radix-4 Booth partial products. It accepts one packed vector of pre-weighted, sign-extended partial-product terms through a valid/ready handshake. It sums the terms one per cycle into a wrapping accumulator and presents the product on a valid/ready output. It sits directly downstream of the booth encoder and is the low-area alternative to a combinational reduction tree.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_term_select.sv | 45 ++++
 rtl/booth_accumulator.sv | 132 +++++++++++++
 tb/tb_booth_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth encoder and the sequential accumulator.
package booth_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Accumulator FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int term_w_f(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int num_terms_f(input int data_width);
    return data_width / 2 + 1;
  endfunction

  // LSB position of term idx inside a packed term vector
  function automatic int term_lsb(input int idx, input int term_w);
    return idx * term_w;
  endfunction

endpackage

// File: rtl/booth_term_select.sv
// Combinational NUM_TERMS:1 term mux; with BOOTH_ACC_ZERO_SKIP_EN it also picks the
// lowest-indexed nonzero term from the mask.
module booth_term_select
  import booth_pkg::*;
#(
  parameter int TERM_W    = 16,
  parameter int NUM_TERMS = 5,
  parameter int CNT_W     = 3
) (
  input  logic [NUM_TERMS*TERM_W-1:0] terms,
`ifdef BOOTH_ACC_ZERO_SKIP_EN
  input  logic [NUM_TERMS-1:0]        mask,
  output logic                        mask_any,
  output logic [CNT_W-1:0]            sel,
`else
  input  logic [CNT_W-1:0]            idx,
`endif
  output logic [TERM_W-1:0]           term
);

  logic [CNT_W-1:0] pick;

`ifdef BOOTH_ACC_ZERO_SKIP_EN
  // Scan downward so the lowest set bit wins.
  always_comb begin
    pick     = '0;
    mask_any = |mask;
    for (int i = NUM_TERMS - 1; i >= 0; i--) begin
      if (mask[i]) pick = CNT_W'(i);
    end
  end
  assign sel = pick;
`else
  assign pick = idx;
`endif

  // NOTE: assign a default before the loop so no path leaves term unassigned (no latch).
  always_comb begin
    term = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      if (pick == CNT_W'(i)) term = terms[term_lsb(i, TERM_W) +: TERM_W];
    end
  end

endmodule

// File: rtl/booth_accumulator.sv
// Sequential radix-4 Booth partial-product accumulator, one term per cycle.
// Optional zero-term skipping is enabled by defining BOOTH_ACC_ZERO_SKIP_EN.
module booth_accumulator
  import booth_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TERM_W     = term_w_f(DATA_WIDTH),
  parameter int NUM_TERMS  = num_terms_f(DATA_WIDTH),
  parameter int CNT_W      = $clog2(NUM_TERMS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_TERMS*TERM_W-1:0] in_terms,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TERM_W-1:0]           out_product
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

  logic [1:0]                  state;
  logic [NUM_TERMS*TERM_W-1:0] terms_q;
  logic [TERM_W-1:0]           acc;
  logic [TERM_W-1:0]           term;
  logic [TERM_W-1:0]           add_term;
  logic [CNT_W-1:0]            idx;
  logic                        accept;
  logic                        last;

  assign in_ready    = (state == ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign out_product = acc;

`ifdef BOOTH_ACC_ZERO_SKIP_EN
  logic [NUM_TERMS-1:0] mask;
  logic [NUM_TERMS-1:0] nz_mask;
  logic [NUM_TERMS-1:0] mask_clr;
  logic                 mask_any;
  logic [CNT_W-1:0]     sel;

  always_comb begin
    nz_mask = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      nz_mask[i] = |in_terms[term_lsb(i, TERM_W) +: TERM_W];
    end
  end

  booth_term_select #(
    .TERM_W   (TERM_W),
    .NUM_TERMS(NUM_TERMS),
    .CNT_W    (CNT_W)
  ) u_term_select (
    .terms   (terms_q),
    .mask    (mask),
    .mask_any(mask_any),
    .sel     (sel),
    .term    (term)
  );

  // An empty mask still spends one ACCUM cycle, adding zero.
  assign mask_clr = mask & ~(NUM_TERMS'(1) << sel);
  assign add_term = mask_any ? term : '0;
  assign last     = (mask_clr == '0);
`else
  booth_term_select #(
    .TERM_W   (TERM_W),
    .NUM_TERMS(NUM_TERMS),
    .CNT_W    (CNT_W)
  ) u_term_select (
    .terms(terms_q),
    .idx  (idx),
    .term (term)
  );

  assign add_term = term;
  assign last     = (idx == LAST_IDX);
`endif

  // NOTE: the term register is a plain data store qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) terms_q <= in_terms;
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
`ifdef BOOTH_ACC_ZERO_SKIP_EN
      mask      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state <= ST_ACCUM;
            acc   <= '0;
            idx   <= '0;
`ifdef BOOTH_ACC_ZERO_SKIP_EN
            mask  <= nz_mask;
`endif
          end
        end
        ST_ACCUM: begin
          acc <= acc + add_term;
`ifdef BOOTH_ACC_ZERO_SKIP_EN
          mask <= mask_clr;
          idx  <= sel + 1'b1;
`else
          idx  <= idx + 1'b1;
`endif
          if (last) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_accumulator.sv
// Self-checking bench for booth_accumulator (DATA_WIDTH=8, NUM_TERMS=5, TERM_W=16),
// scoreboard-based; honours BOOTH_ACC_ZERO_SKIP_EN for latency expectations.
module tb_booth_accumulator;

  localparam int DW = 8;
  localparam int TW = 16;
  localparam int NT = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NT*TW-1:0] in_terms;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_product;

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] exp_q[$];

  booth_accumulator #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_terms   (in_terms),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BOOTH_ACC_ZERO_SKIP_EN
  localparam int LAT_BASIC = 3;
  localparam int LAT_ZERO  = 1;
`else
  localparam int LAT_BASIC = 5;
  localparam int LAT_ZERO  = 5;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NT*TW-1:0] pack5(input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                                             input logic [TW-1:0] t2, input logic [TW-1:0] t3,
                                             input logic [TW-1:0] t4);
    return {t4, t3, t2, t1, t0};
  endfunction

  // Reference radix-4 Booth encoder for signed 8-bit operands; the fifth term is zero.
  function automatic logic [NT*TW-1:0] booth_terms(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [NT*TW-1:0] v;
    logic [DW:0]      bb;
    logic signed [TW-1:0] as;
    logic signed [TW-1:0] t;
    v  = '0;
    bb = {b, 1'b0};
    as = TW'($signed(a));
    for (int j = 0; j < DW / 2; j++) begin
      case (bb[2*j +: 3])
        3'b001, 3'b010: t = as;
        3'b011:         t = as <<< 1;
        3'b100:         t = -(as <<< 1);
        3'b101, 3'b110: t = -as;
        default:        t = '0;
      endcase
      v[j*TW +: TW] = t <<< (2 * j);
    end
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [NT*TW-1:0] v, input logic [TW-1:0] e);
    int n = 0;
    in_terms = v;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(n < 100), 32'd1);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_terms = {16'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  // Called at the negedge after acceptance; lat < 0 skips the latency comparison.
  task automatic receive(input string tag, input int lat);
    int n = 0;
    logic [TW-1:0] e;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (lat >= 0) check({tag, "_latency"}, n, lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_product"}, 32'(out_product), 32'(e));
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_ready_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    end
  endtask

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] p;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_terms  = '0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_product", 32'(out_product), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {30'd0, in_ready, out_valid}, 32'b10);

    // Basic sum
    send(pack5(16'h0005, 16'hFFFE, 16'h0000, 16'h0010, 16'h0000), 16'h0013);
    receive("basic", LAT_BASIC);

    // Wrap-around
    send(pack5(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFB);
    receive("wrap_neg", 5);
    send(pack5(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000), 16'h4000);
    receive("wrap_pos", 5);

    // All-zero vector
    send('0, 16'h0000);
    receive("zero", LAT_ZERO);

    // Backpressure with a pending vector held on the input
    out_ready = 1'b0;
    send(pack5(16'h0005, 16'hFFFE, 16'h0000, 16'h0010, 16'h0000), 16'h0013);
    receive("bp_first", LAT_BASIC);
    in_terms = pack5(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {14'd0, out_valid, in_ready, out_product}, {14'd0, 1'b1, 1'b0, 16'h0013});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
    exp_q.push_back(16'h000F);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    receive("bp_second", 5);

    // Reset mid-operation at idx=2
    send(pack5(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005), 16'h000F);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_state", {14'd0, in_ready, out_valid, out_product}, {14'd0, 1'b1, 1'b0, 16'h0000});
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    send(pack5(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005), 16'h000F);
    receive("after_abort", 5);

    // Random regression through the reference encoder
    for (int k = 0; k < 1000; k++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      p = TW'($signed(a) * $signed(b));
      send(booth_terms(a, b), p);
      receive("rand", -1);
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
